reg_scoreboard: RTL and testbench
=================================

# reg_scoreboard

Parametrised register-busy scoreboard for the pipelined core, built around an enabled ID_W:2^ID_W one-hot decoder. A producer's destination id is decoded into a one-hot set line that marks the register busy. Writeback decodes its id into a clear line that releases the register. Decode-stage source queries return busy status and a combined stall.

## Interface
- ID_W, 4: register id width; N = 2**ID_W entries.
- ZERO_REG, 1: when 1, entry 0 is hardwired not-busy (set and clear ignored); when 0, entry 0 is an ordinary entry.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all busy state (pipeline squash).
- set_en  in  1  mark set_id busy.
- set_id  in  ID_W  destination id of the issuing instruction.
- clr_en  in  1  release clr_id.
- clr_id  in  ID_W  writeback destination id.
- rs_vld, rt_vld  in  1 each  source operand is actually read.
- rs_id, rt_id  in  ID_W each  source ids.
- rs_busy, rt_busy  out  1 each  combinational busy lookup of rs_id / rt_id.
- stall  out  1  (rs_vld & rs_busy) | (rt_vld & rt_busy).
- busy_vec  out  N  registered busy bits, bit i = entry i.
- busy_cnt  out  ID_W+1  registered population count of busy_vec.
- set_line  out  N  registered one-hot of the set accepted last cycle, else 0.
- err_clr_idle  out  1  registered one-cycle pulse: clear issued to an entry that was not busy.

## Operation
- Decode: set_dec = set_en ? onehot(set_id) : 0; clr_dec = clr_en ? onehot(clr_id) : 0. With ZERO_REG=1, bit 0 of both is forced to 0.
- Next state is computed from busy_vec, set_dec and clr_dec, in priority order:
  - flush: busy_next = 0.
  - otherwise: busy_next = (busy_vec & ~clr_dec) | set_dec.
- Same-cycle set and clear of one id: set wins, and the entry remains/becomes busy (the new producer supersedes the old).
- Set of an already-busy entry: the entry stays busy (a single bit, no nesting); set_line still pulses.
- Flush with set_en in the same cycle: flush wins, and set_line is 0 the next cycle.
- err_clr_idle: next = clr_en & ~flush & ~busy_vec[clr_id] & ~(ZERO_REG & clr_id==0). It does not assert when set_en targets the same id in that cycle.
- busy_cnt always equals popcount(busy_vec). It is updated from busy_next in the same register stage, so the two never disagree.
- Queries: rs_busy = busy_vec[rs_id], modified by the configuration below. With ZERO_REG=1, id 0 always reads 0.

## Timing
- Reset (async assert, sync-safe release): busy_vec=0, busy_cnt=0, set_line=0, err_clr_idle=0. rs_busy, rt_busy and stall are therefore 0.
- Set/clear latency is 1 cycle: an edge with set_en=1 makes busy_vec[set_id]=1 after that edge.
- Queries have zero latency (combinational) from the current busy_vec and, if bypass is enabled, from the current clr inputs.
- Reset asserted mid-operation clears everything immediately, regardless of clk.
- No handshake; every asserted enable is accepted in its cycle.

## Configuration
- SCOREBOARD_BYPASS_EN defined:
  - rs_busy = busy_vec[rs_id] & ~clr_dec[rs_id]; likewise for rt_busy.
  - A register written back this cycle reads not-busy, removing one stall cycle.
  - A same-cycle set does not affect the query.
- Not defined: queries see busy_vec only, and a released register stalls until the cycle after clr_en.

## Test plan
- Reset, then set_en=1, set_id=5 for one cycle -> busy_vec=16'h0020, busy_cnt=1, set_line=16'h0020 for one cycle; rs_id=5, rs_vld=1 -> stall=1.
- Entry 5 busy; clr_en=1, clr_id=5 with rs_id=5, rs_vld=1 -> stall=0 that cycle with SCOREBOARD_BYPASS_EN, stall=1 without; busy_vec=0 the next cycle.
- set_en and clr_en both on id 9 while 9 is busy -> 9 remains busy, busy_cnt unchanged, err_clr_idle=0.
- ZERO_REG=1: set_id=0 -> busy_vec stays 0, set_line=0; rt_id=0, rt_vld=1 -> stall=0.
- Set ids 1..15 over 15 cycles -> busy_cnt=15 and busy_vec=16'hFFFE; then flush with set_en=1, set_id=3 -> busy_vec=0, busy_cnt=0, set_line=0.
- clr_en=1, clr_id=7 while 7 is idle -> err_clr_idle pulses for exactly one cycle. Assert rst asynchronously between edges while entries are busy -> all outputs 0 immediately.

Source files
------------

// File: rtl/reg_scoreboard_if.sv
// Scoreboard port bundle: issue set, writeback clear, decode-stage source queries and status.
interface reg_scoreboard_if #(
  parameter int ID_W = 4
);
  localparam int N = 1 << ID_W;

  logic            flush;
  logic            set_en;
  logic [ID_W-1:0] set_id;
  logic            clr_en;
  logic [ID_W-1:0] clr_id;
  logic            rs_vld;
  logic [ID_W-1:0] rs_id;
  logic            rt_vld;
  logic [ID_W-1:0] rt_id;
  logic            rs_busy;
  logic            rt_busy;
  logic            stall;
  logic [N-1:0]    busy_vec;
  logic [ID_W:0]   busy_cnt;
  logic [N-1:0]    set_line;
  logic            err_clr_idle;

  modport master (
    output flush, set_en, set_id, clr_en, clr_id, rs_vld, rs_id, rt_vld, rt_id,
    input  rs_busy, rt_busy, stall, busy_vec, busy_cnt, set_line, err_clr_idle
  );

  modport slave (
    input  flush, set_en, set_id, clr_en, clr_id, rs_vld, rs_id, rt_vld, rt_id,
    output rs_busy, rt_busy, stall, busy_vec, busy_cnt, set_line, err_clr_idle
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register-busy scoreboard; SCOREBOARD_BYPASS_EN lets a same-cycle writeback read not-busy.
// Latency: set/clear visible 1 cycle later; rs/rt busy and stall are combinational.
// Backpressure: none, every enable is accepted in its cycle; stall is the only throttle.
module reg_scoreboard #(
  parameter int ID_W     = 4,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  reg_scoreboard_if.slave sb
);
  localparam int N = 1 << ID_W;

  logic [N-1:0]  set_dec;
  logic [N-1:0]  clr_dec;
  logic [N-1:0]  busy_next;
  logic [N-1:0]  busy_q;
  logic [N-1:0]  set_line_q;
  logic [ID_W:0] busy_cnt_q;
  logic          err_q;
  logic          err_next;
  logic          rs_busy_w;
  logic          rt_busy_w;

  function automatic logic [ID_W:0] popcnt(input logic [N-1:0] v);
    logic [ID_W:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + {{ID_W{1'b0}}, v[i]};
    return c;
  endfunction

  always_comb begin
    set_dec = '0;
    clr_dec = '0;
    if (sb.set_en) set_dec[sb.set_id] = 1'b1;
    if (sb.clr_en) clr_dec[sb.clr_id] = 1'b1;
    if (ZERO_REG != 0) begin
      set_dec[0] = 1'b0;
      clr_dec[0] = 1'b0;
    end
    busy_next = sb.flush ? '0 : ((busy_q & ~clr_dec) | set_dec);
  end

  // A set landing on the same id as the clear means a new producer, not a stray release.
  always_comb begin
    err_next = sb.clr_en & ~sb.flush & ~busy_q[sb.clr_id];
    if ((ZERO_REG != 0) && (sb.clr_id == '0)) err_next = 1'b0;
    if (sb.set_en && (sb.set_id == sb.clr_id)) err_next = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
      set_line_q <= '0;
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_next;
      busy_cnt_q <= popcnt(busy_next);
      set_line_q <= sb.flush ? '0 : set_dec;
      err_q      <= err_next;
    end
  end

  always_comb begin
`ifdef SCOREBOARD_BYPASS_EN
    rs_busy_w = busy_q[sb.rs_id] & ~clr_dec[sb.rs_id];
    rt_busy_w = busy_q[sb.rt_id] & ~clr_dec[sb.rt_id];
`else
    rs_busy_w = busy_q[sb.rs_id];
    rt_busy_w = busy_q[sb.rt_id];
`endif
    if ((ZERO_REG != 0) && (sb.rs_id == '0)) rs_busy_w = 1'b0;
    if ((ZERO_REG != 0) && (sb.rt_id == '0)) rt_busy_w = 1'b0;
  end

  assign sb.rs_busy      = rs_busy_w;
  assign sb.rt_busy      = rt_busy_w;
  assign sb.stall        = (sb.rs_vld & rs_busy_w) | (sb.rt_vld & rt_busy_w);
  assign sb.busy_vec     = busy_q;
  assign sb.busy_cnt     = busy_cnt_q;
  assign sb.set_line     = set_line_q;
  assign sb.err_clr_idle = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard (ID_W=4, ZERO_REG=1), hand-computed expectations.
module tb_reg_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  reg_scoreboard_if #(.ID_W(4)) sb_if ();

  reg_scoreboard #(.ID_W(4), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  task automatic idle();
    sb_if.flush  = 1'b0;
    sb_if.set_en = 1'b0;
    sb_if.set_id = '0;
    sb_if.clr_en = 1'b0;
    sb_if.clr_id = '0;
    sb_if.rs_vld = 1'b0;
    sb_if.rs_id  = '0;
    sb_if.rt_vld = 1'b0;
    sb_if.rt_id  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    sb_if.rs_vld = 1'b1;
    sb_if.rs_id  = 4'd5;
    #12;
    checks++; if (sb_if.busy_vec !== 16'h0000) begin errors++; $display("FAIL reset_busy_vec got=%h exp=0000", sb_if.busy_vec); end
    checks++; if (sb_if.busy_cnt !== 5'd0) begin errors++; $display("FAIL reset_busy_cnt got=%0d exp=0", sb_if.busy_cnt); end
    checks++; if (sb_if.set_line !== 16'h0000) begin errors++; $display("FAIL reset_set_line got=%h exp=0000", sb_if.set_line); end
    checks++; if (sb_if.err_clr_idle !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", sb_if.err_clr_idle); end
    checks++; if (sb_if.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", sb_if.stall); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    idle();
  endtask

  task automatic test_set();
    sb_if.set_en = 1'b1;
    sb_if.set_id = 4'd5;
    tick();
    sb_if.set_en = 1'b0;
    sb_if.rs_vld = 1'b1;
    sb_if.rs_id  = 4'd5;
    #1;
    checks++; if (sb_if.busy_vec !== 16'h0020) begin errors++; $display("FAIL set_busy_vec got=%h exp=0020", sb_if.busy_vec); end
    checks++; if (sb_if.busy_cnt !== 5'd1) begin errors++; $display("FAIL set_busy_cnt got=%0d exp=1", sb_if.busy_cnt); end
    checks++; if (sb_if.set_line !== 16'h0020) begin errors++; $display("FAIL set_line got=%h exp=0020", sb_if.set_line); end
    checks++; if (sb_if.stall !== 1'b1) begin errors++; $display("FAIL set_stall got=%b exp=1", sb_if.stall); end
    tick();
    checks++; if (sb_if.set_line !== 16'h0000) begin errors++; $display("FAIL set_line_pulse got=%h exp=0000", sb_if.set_line); end
    idle();
  endtask

  task automatic test_clear_bypass();
    logic exp_stall;
`ifdef SCOREBOARD_BYPASS_EN
    exp_stall = 1'b0;
`else
    exp_stall = 1'b1;
`endif
    sb_if.clr_en = 1'b1;
    sb_if.clr_id = 4'd5;
    sb_if.rs_vld = 1'b1;
    sb_if.rs_id  = 4'd5;
    #1;
    checks++; if (sb_if.stall !== exp_stall) begin errors++; $display("FAIL clr_stall got=%b exp=%b", sb_if.stall, exp_stall); end
    tick();
    idle();
    #1;
    checks++; if (sb_if.busy_vec !== 16'h0000) begin errors++; $display("FAIL clr_busy_vec got=%h exp=0000", sb_if.busy_vec); end
    checks++; if (sb_if.busy_cnt !== 5'd0) begin errors++; $display("FAIL clr_busy_cnt got=%0d exp=0", sb_if.busy_cnt); end
    checks++; if (sb_if.err_clr_idle !== 1'b0) begin errors++; $display("FAIL clr_err got=%b exp=0", sb_if.err_clr_idle); end
  endtask

  task automatic test_set_clr_same();
    sb_if.set_en = 1'b1;
    sb_if.set_id = 4'd9;
    tick();
    sb_if.clr_en = 1'b1;
    sb_if.clr_id = 4'd9;
    tick();
    idle();
    checks++; if (sb_if.busy_vec !== 16'h0200) begin errors++; $display("FAIL same_busy_vec got=%h exp=0200", sb_if.busy_vec); end
    checks++; if (sb_if.busy_cnt !== 5'd1) begin errors++; $display("FAIL same_busy_cnt got=%0d exp=1", sb_if.busy_cnt); end
    checks++; if (sb_if.err_clr_idle !== 1'b0) begin errors++; $display("FAIL same_err got=%b exp=0", sb_if.err_clr_idle); end
    checks++; if (sb_if.set_line !== 16'h0200) begin errors++; $display("FAIL same_set_line got=%h exp=0200", sb_if.set_line); end
    // set and clear together on an idle entry: becomes busy, no error
    sb_if.clr_en = 1'b1;
    sb_if.clr_id = 4'd9;
    tick();
    sb_if.set_en = 1'b1;
    sb_if.set_id = 4'd2;
    sb_if.clr_id = 4'd2;
    tick();
    idle();
    checks++; if (sb_if.busy_vec !== 16'h0004) begin errors++; $display("FAIL idle_same_busy_vec got=%h exp=0004", sb_if.busy_vec); end
    checks++; if (sb_if.err_clr_idle !== 1'b0) begin errors++; $display("FAIL idle_same_err got=%b exp=0", sb_if.err_clr_idle); end
    sb_if.clr_en = 1'b1;
    sb_if.clr_id = 4'd2;
    tick();
    idle();
  endtask

  task automatic test_zero_reg();
    sb_if.set_en = 1'b1;
    sb_if.set_id = 4'd0;
    tick();
    idle();
    sb_if.rt_vld = 1'b1;
    sb_if.rt_id  = 4'd0;
    #1;
    checks++; if (sb_if.busy_vec !== 16'h0000) begin errors++; $display("FAIL zero_busy_vec got=%h exp=0000", sb_if.busy_vec); end
    checks++; if (sb_if.set_line !== 16'h0000) begin errors++; $display("FAIL zero_set_line got=%h exp=0000", sb_if.set_line); end
    checks++; if (sb_if.stall !== 1'b0) begin errors++; $display("FAIL zero_stall got=%b exp=0", sb_if.stall); end
    sb_if.clr_en = 1'b1;
    sb_if.clr_id = 4'd0;
    tick();
    idle();
    checks++; if (sb_if.err_clr_idle !== 1'b0) begin errors++; $display("FAIL zero_err got=%b exp=0", sb_if.err_clr_idle); end
  endtask

  task automatic test_fill_flush();
    for (int i = 1; i < 16; i++) begin
      sb_if.set_en = 1'b1;
      sb_if.set_id = 4'(i);
      tick();
    end
    idle();
    checks++; if (sb_if.busy_cnt !== 5'd15) begin errors++; $display("FAIL fill_busy_cnt got=%0d exp=15", sb_if.busy_cnt); end
    checks++; if (sb_if.busy_vec !== 16'hFFFE) begin errors++; $display("FAIL fill_busy_vec got=%h exp=fffe", sb_if.busy_vec); end
    sb_if.set_en = 1'b1;
    sb_if.set_id = 4'd4;
    tick();
    idle();
    checks++; if (sb_if.busy_cnt !== 5'd15) begin errors++; $display("FAIL reset_busy_cnt_rebusy got=%0d exp=15", sb_if.busy_cnt); end
    checks++; if (sb_if.set_line !== 16'h0010) begin errors++; $display("FAIL rebusy_set_line got=%h exp=0010", sb_if.set_line); end
    sb_if.flush  = 1'b1;
    sb_if.set_en = 1'b1;
    sb_if.set_id = 4'd3;
    tick();
    idle();
    checks++; if (sb_if.busy_vec !== 16'h0000) begin errors++; $display("FAIL flush_busy_vec got=%h exp=0000", sb_if.busy_vec); end
    checks++; if (sb_if.busy_cnt !== 5'd0) begin errors++; $display("FAIL flush_busy_cnt got=%0d exp=0", sb_if.busy_cnt); end
    checks++; if (sb_if.set_line !== 16'h0000) begin errors++; $display("FAIL flush_set_line got=%h exp=0000", sb_if.set_line); end
  endtask

  task automatic test_err_idle();
    sb_if.clr_en = 1'b1;
    sb_if.clr_id = 4'd7;
    tick();
    idle();
    checks++; if (sb_if.err_clr_idle !== 1'b1) begin errors++; $display("FAIL err_pulse got=%b exp=1", sb_if.err_clr_idle); end
    tick();
    checks++; if (sb_if.err_clr_idle !== 1'b0) begin errors++; $display("FAIL err_one_cycle got=%b exp=0", sb_if.err_clr_idle); end
    sb_if.clr_en = 1'b1;
    sb_if.clr_id = 4'd7;
    sb_if.flush  = 1'b1;
    tick();
    idle();
    checks++; if (sb_if.err_clr_idle !== 1'b0) begin errors++; $display("FAIL err_flush got=%b exp=0", sb_if.err_clr_idle); end
  endtask

  task automatic test_async_reset();
    sb_if.set_en = 1'b1;
    sb_if.set_id = 4'd1;
    tick();
    sb_if.set_id = 4'd2;
    tick();
    idle();
    sb_if.rs_vld = 1'b1;
    sb_if.rs_id  = 4'd2;
    checks++; if (sb_if.busy_vec !== 16'h0006) begin errors++; $display("FAIL pre_rst_busy_vec got=%h exp=0006", sb_if.busy_vec); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (sb_if.busy_vec !== 16'h0000) begin errors++; $display("FAIL arst_busy_vec got=%h exp=0000", sb_if.busy_vec); end
    checks++; if (sb_if.busy_cnt !== 5'd0) begin errors++; $display("FAIL arst_busy_cnt got=%0d exp=0", sb_if.busy_cnt); end
    checks++; if (sb_if.set_line !== 16'h0000) begin errors++; $display("FAIL arst_set_line got=%h exp=0000", sb_if.set_line); end
    checks++; if (sb_if.stall !== 1'b0) begin errors++; $display("FAIL arst_stall got=%b exp=0", sb_if.stall); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++; if (sb_if.busy_vec !== 16'h0000) begin errors++; $display("FAIL post_rst_busy_vec got=%h exp=0000", sb_if.busy_vec); end
    idle();
  endtask

  initial begin
    test_reset();
    test_set();
    test_clear_bypass();
    test_set_clr_same();
    test_zero_reg();
    test_fill_flush();
    test_err_idle();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
